// File: rtl/fifo_rd_stream.sv
//-----------------------------------------------------------------------------
// fifo_rd_stream
//
// Read-side drain engine for a synchronous FIFO that has registered read data.
// The engine issues read strobes on a credit basis and captures each returned
// word into a 3-entry buffer. Words leave the buffer on a valid/ready stream,
// up to one word per clock. The engine also counts delivered words and
// supports a synchronous flush.
//
// Ports
//   clk          : clock, all state changes on the rising edge
//   rst_n        : asynchronous active-low reset
//   fifo_rd_date : FIFO read data, valid the cycle after an accepted read
//   fifo_empty   : FIFO empty flag
//   fifo_cnt     : FIFO occupancy, used only for the drained flag
//   fifo_rd_en   : read strobe to the FIFO
//   m_valid      : output word valid
//   m_data       : output word (head of the buffer)
//   m_ready      : consumer accepts m_data
//   flush        : synchronous discard of buffered and in-flight words
//   words_out    : delivered word count, wraps at 16 bits, cleared by reset
//   drained      : FIFO, pipeline and buffer are all empty
//-----------------------------------------------------------------------------
`timescale 1ns/1ps
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 3,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] fifo_rd_date,
  input  logic                  fifo_empty,
  input  logic [ADDR_WIDTH:0]   fifo_cnt,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  input  logic                  flush,
  output logic [15:0]           words_out,
  output logic                  drained
);

  // Buffer pointers step 0 -> 1 -> 2 -> 0; the value 3 is never produced.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  logic                  pend_q, pend_d;
  logic [1:0]            buf_cnt_q, buf_cnt_d;
  logic [1:0]            wr_ptr_q, wr_ptr_d;
  logic [1:0]            rd_ptr_q, rd_ptr_d;
  logic [15:0]           words_q, words_d;
  logic [DATA_WIDTH-1:0] entry_q [3];

  logic [2:0] credit;
  logic       rd_acc;
  logic       capture;
  logic       pop;

  // Credit counts both buffered words and the word still in flight from the
  // FIFO. The strobe deliberately ignores fifo_empty and m_ready: the FIFO's
  // empty flag depends on rd_en, so either term would close a combinational
  // loop through the FIFO.
  always_comb begin
    credit     = {1'b0, buf_cnt_q} + {2'b00, pend_q};
    fifo_rd_en = rst_n && !flush && (credit < 3'd3);
    rd_acc     = fifo_rd_en && !fifo_empty;
    capture    = pend_q && !flush;
    pop        = m_valid && m_ready && !flush;
  end

  always_comb begin
    pend_d    = rd_acc;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    buf_cnt_d = buf_cnt_q;
    words_d   = words_q;

    if (pop) begin
      words_d = words_q + 16'd1;
    end

    if (flush) begin
      wr_ptr_d  = 2'd0;
      rd_ptr_d  = 2'd0;
      buf_cnt_d = 2'd0;
    end else begin
      if (capture) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({capture, pop})
        2'b10:   buf_cnt_d = buf_cnt_q + 2'd1;
        2'b01:   buf_cnt_d = buf_cnt_q - 2'd1;
        default: buf_cnt_d = buf_cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q    <= 1'b0;
      buf_cnt_q <= 2'd0;
      wr_ptr_q  <= 2'd0;
      rd_ptr_q  <= 2'd0;
      words_q   <= 16'd0;
    end else begin
      pend_q    <= pend_d;
      buf_cnt_q <= buf_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      words_q   <= words_d;
    end
  end

  // Entries are zeroed by reset so m_data reads 0 while in reset. Flush
  // leaves them untouched; only the pointers and count are cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (capture && (wr_ptr_q == 2'(i))) begin
          entry_q[i] <= fifo_rd_date;
        end
      end
    end
  end

  always_comb begin
    m_valid   = (buf_cnt_q != 2'd0);
    words_out = words_q;
    drained   = fifo_empty && (fifo_cnt == '0) && !pend_q && (buf_cnt_q == 2'd0);
    case (rd_ptr_q)
      2'd1:    m_data = entry_q[1];
      2'd2:    m_data = entry_q[2];
      default: m_data = entry_q[0];
    endcase
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
`timescale 1ns/1ps
module tb_fifo_rd_stream;

  logic        clk;
  logic        rst_n;
  logic [2:0]  fifo_rd_date;
  logic        fifo_empty;
  logic [3:0]  fifo_cnt;
  logic        fifo_rd_en;
  logic        m_valid;
  logic [2:0]  m_data;
  logic        m_ready;
  logic        flush;
  logic [15:0] words_out;
  logic        drained;

  int n_checks = 0;
  int n_fail   = 0;
  int inv_err  = 0;

  fifo_rd_stream #(.DATA_WIDTH(3), .ADDR_WIDTH(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fifo_rd_date (fifo_rd_date),
    .fifo_empty   (fifo_empty),
    .fifo_cnt     (fifo_cnt),
    .fifo_rd_en   (fifo_rd_en),
    .m_valid      (m_valid),
    .m_data       (m_data),
    .m_ready      (m_ready),
    .flush        (flush),
    .words_out    (words_out),
    .drained      (drained)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 8-deep synchronous FIFO with registered read data.
  logic [2:0] fmem [8];
  logic [2:0] fwp, frp;
  logic       fwr_en;
  logic [2:0] fwr_data;
  logic       do_rd, do_wr;

  assign fifo_empty = (fifo_cnt == 4'd0);
  assign do_rd = fifo_rd_en && !fifo_empty;
  assign do_wr = fwr_en && (fifo_cnt != 4'd8);

  always @(posedge clk) begin
    if (do_wr) fmem[fwp] <= fwr_data;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwp          <= 3'd0;
      frp          <= 3'd0;
      fifo_cnt     <= 4'd0;
      fifo_rd_date <= 3'd0;
    end else begin
      if (do_wr) fwp <= fwp + 3'd1;
      if (do_rd) begin
        fifo_rd_date <= fmem[frp];
        frp          <= frp + 3'd1;
      end
      if (do_wr && !do_rd)      fifo_cnt <= fifo_cnt + 4'd1;
      else if (!do_wr && do_rd) fifo_cnt <= fifo_cnt - 4'd1;
    end
  end

  // Buffer occupancy plus in-flight word must never exceed the 3 entries.
  always @(posedge clk) begin
    if (rst_n) begin
      if (int'(dut.buf_cnt_q) + int'(dut.pend_q) > 3) inv_err++;
      if (dut.wr_ptr_q == 2'd3 || dut.rd_ptr_q == 2'd3) inv_err++;
    end
  end

  task automatic do_reset();
    rst_n   = 1'b0;
    flush   = 1'b0;
    m_ready = 1'b0;
    fwr_en  = 1'b0;
    fwr_data = 3'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Writes one word into the FIFO while flush holds the engine idle.
  task automatic load_word(input logic [2:0] v);
    @(negedge clk);
    flush    = 1'b1;
    fwr_en   = 1'b1;
    fwr_data = v;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; m_ready = 1'b1; fwr_en = 1'b0; fwr_data = 3'd0;
    @(negedge clk); #1;
    n_checks++;
    if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en); end
    n_checks++;
    if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
    n_checks++;
    if (m_data !== 3'd0) begin n_fail++; $display("FAIL reset_m_data: got %0d want 0", m_data); end
    n_checks++;
    if (words_out !== 16'd0) begin n_fail++; $display("FAIL reset_words_out: got %0d want 0", words_out); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL post_reset_rd_en: got %b want 1", fifo_rd_en); end
    n_checks++;
    if (drained !== 1'b1) begin n_fail++; $display("FAIL post_reset_drained: got %b want 1", drained); end
  endtask

  task automatic test_basic_stream();
    logic [2:0] exp_w [3];
    exp_w[0] = 3'd5; exp_w[1] = 3'd1; exp_w[2] = 3'd7;
    do_reset();
    load_word(3'd5); load_word(3'd1); load_word(3'd7);
    @(negedge clk);
    fwr_en = 1'b0; flush = 1'b0; m_ready = 1'b1;
    #1;
    n_checks++;
    if (fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL basic_first_rd_en: got %b want 1", fifo_rd_en); end
    @(negedge clk); #1;
    n_checks++;
    if (m_valid !== 1'b0) begin n_fail++; $display("FAIL basic_latency_valid: got %b want 0", m_valid); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_checks++;
      if (m_valid !== 1'b1 || m_data !== exp_w[i]) begin
        n_fail++; $display("FAIL basic_word%0d: got valid=%b data=%0d want valid=1 data=%0d", i, m_valid, m_data, exp_w[i]);
      end
    end
    @(negedge clk); #1;
    n_checks++;
    if (m_valid !== 1'b0) begin n_fail++; $display("FAIL basic_end_valid: got %b want 0", m_valid); end
    n_checks++;
    if (words_out !== 16'd3) begin n_fail++; $display("FAIL basic_words_out: got %0d want 3", words_out); end
    n_checks++;
    if (drained !== 1'b1) begin n_fail++; $display("FAIL basic_drained: got %b want 1", drained); end
  endtask

  task automatic test_empty_fifo();
    // Continues from the drained state of the previous scenario.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      n_checks++;
      if (fifo_rd_en !== 1'b1 || dut.pend_q !== 1'b0 || m_valid !== 1'b0) begin
        n_fail++; $display("FAIL empty_idle%0d: got rd_en=%b pend=%b valid=%b want 1 0 0", i, fifo_rd_en, dut.pend_q, m_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [2:0] vals [8];
    int acc, got, first_pop, gap;
    vals[0]=3'd2; vals[1]=3'd4; vals[2]=3'd6; vals[3]=3'd1;
    vals[4]=3'd3; vals[5]=3'd5; vals[6]=3'd7; vals[7]=3'd0;
    do_reset();
    for (int i = 0; i < 8; i++) load_word(vals[i]);
    @(negedge clk);
    fwr_en = 1'b0; flush = 1'b0; m_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (do_rd) acc++;
    end
    n_checks++;
    if (acc !== 3) begin n_fail++; $display("FAIL bp_reads: got %0d want 3", acc); end
    n_checks++;
    if (dut.buf_cnt_q !== 2'd3) begin n_fail++; $display("FAIL bp_buf_cnt: got %0d want 3", dut.buf_cnt_q); end
    n_checks++;
    if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL bp_rd_en: got %b want 0", fifo_rd_en); end
    n_checks++;
    if (fifo_cnt !== 4'd5) begin n_fail++; $display("FAIL bp_fifo_cnt: got %0d want 5", fifo_cnt); end
    got = 0; first_pop = 1; gap = 0;
    for (int c = 0; c < 40 && got < 8; c++) begin
      @(negedge clk);
      m_ready = 1'b1;
      #1;
      if (c == 0) begin
        n_checks++;
        if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL bp_resume_rd_en0: got %b want 0", fifo_rd_en); end
      end
      if (c == 1) begin
        n_checks++;
        if (fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL bp_resume_rd_en1: got %b want 1", fifo_rd_en); end
      end
      if (m_valid) begin
        n_checks++;
        if (m_data !== vals[got]) begin n_fail++; $display("FAIL bp_word%0d: got %0d want %0d", got, m_data, vals[got]); end
        got++;
        first_pop = 0;
      end else if (!first_pop) begin
        gap++;
      end
    end
    n_checks++;
    if (got !== 8 || gap !== 0) begin n_fail++; $display("FAIL bp_drain: got words=%0d gaps=%0d want 8 0", got, gap); end
    @(negedge clk); #1;
    n_checks++;
    if (words_out !== 16'd8) begin n_fail++; $display("FAIL bp_words_out: got %0d want 8", words_out); end
  endtask

  task automatic test_toggle_wrap();
    int widx, ridx;
    do_reset();
    widx = 0; ridx = 0;
    for (int c = 0; c < 300 && ridx < 20; c++) begin
      @(negedge clk);
      m_ready  = (c % 2 == 0);
      fwr_en   = (widx < 20) && (fifo_cnt != 4'd8);
      fwr_data = 3'(widx % 8);
      if (fwr_en) widx++;
      #1;
      if (m_valid && m_ready) begin
        n_checks++;
        if (m_data !== 3'(ridx % 8)) begin n_fail++; $display("FAIL toggle_word%0d: got %0d want %0d", ridx, m_data, ridx % 8); end
        ridx++;
      end
    end
    @(negedge clk);
    fwr_en = 1'b0; m_ready = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    n_checks++;
    if (ridx !== 20 || words_out !== 16'd20) begin
      n_fail++; $display("FAIL toggle_count: got popped=%0d words_out=%0d want 20 20", ridx, words_out);
    end
    n_checks++;
    if (m_valid !== 1'b0 || drained !== 1'b1) begin
      n_fail++; $display("FAIL toggle_tail: got valid=%b drained=%b want 0 1", m_valid, drained);
    end
  endtask

  task automatic test_flush();
    int got;
    logic [2:0] exp_w;
    do_reset();
    for (int i = 1; i <= 6; i++) load_word(3'(i));
    @(negedge clk);
    fwr_en = 1'b0; flush = 1'b0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (dut.buf_cnt_q !== 2'd2 || dut.pend_q !== 1'b1) begin
      n_fail++; $display("FAIL flush_setup: got buf_cnt=%0d pend=%b want 2 1", dut.buf_cnt_q, dut.pend_q);
    end
    flush = 1'b1; m_ready = 1'b1;
    #1;
    n_checks++;
    if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL flush_rd_en: got %b want 0", fifo_rd_en); end
    @(negedge clk);
    flush = 1'b0;
    #1;
    n_checks++;
    if (m_valid !== 1'b0 || dut.buf_cnt_q !== 2'd0 || dut.pend_q !== 1'b0) begin
      n_fail++; $display("FAIL flush_clear: got valid=%b buf_cnt=%0d pend=%b want 0 0 0", m_valid, dut.buf_cnt_q, dut.pend_q);
    end
    n_checks++;
    if (words_out !== 16'd0) begin n_fail++; $display("FAIL flush_words_out: got %0d want 0", words_out); end
    n_checks++;
    if (fifo_cnt !== 4'd3) begin n_fail++; $display("FAIL flush_fifo_cnt: got %0d want 3", fifo_cnt); end
    got = 0;
    for (int c = 0; c < 20 && got < 3; c++) begin
      @(negedge clk); #1;
      if (m_valid) begin
        exp_w = 3'(4 + got);
        n_checks++;
        if (m_data !== exp_w) begin n_fail++; $display("FAIL flush_after_word%0d: got %0d want %0d", got, m_data, exp_w); end
        got++;
      end
    end
    @(negedge clk); #1;
    n_checks++;
    if (words_out !== 16'd3) begin n_fail++; $display("FAIL flush_after_count: got %0d want 3", words_out); end
  endtask

  task automatic test_async_reset();
    logic [2:0] vals [3];
    int got, c;
    vals[0] = 3'd6; vals[1] = 3'd3; vals[2] = 3'd5;
    do_reset();
    for (int i = 1; i <= 8; i++) load_word(3'(i % 8));
    @(negedge clk);
    fwr_en = 1'b0; flush = 1'b0; m_ready = 1'b1;
    c = 0;
    while (words_out != 16'd2 && c < 50) begin
      @(negedge clk); #1;
      c++;
    end
    n_checks++;
    if (m_valid !== 1'b1 || words_out !== 16'd2) begin
      n_fail++; $display("FAIL areset_pre: got valid=%b words_out=%0d want 1 2", m_valid, words_out);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (m_valid !== 1'b0 || fifo_rd_en !== 1'b0 || words_out !== 16'd0 || m_data !== 3'd0) begin
      n_fail++; $display("FAIL areset_now: got valid=%b rd_en=%b words=%0d data=%0d want 0 0 0 0", m_valid, fifo_rd_en, words_out, m_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) load_word(vals[i]);
    @(negedge clk);
    fwr_en = 1'b0; flush = 1'b0; m_ready = 1'b1;
    got = 0;
    for (int k = 0; k < 20 && got < 3; k++) begin
      @(negedge clk); #1;
      if (m_valid) begin
        n_checks++;
        if (m_data !== vals[got]) begin n_fail++; $display("FAIL areset_resume_word%0d: got %0d want %0d", got, m_data, vals[got]); end
        got++;
      end
    end
    @(negedge clk); #1;
    n_checks++;
    if (words_out !== 16'd3) begin n_fail++; $display("FAIL areset_resume_count: got %0d want 3", words_out); end
  endtask

  task automatic test_counter_wrap();
    int c;
    do_reset();
    @(negedge clk);
    fwr_en = 1'b1; fwr_data = 3'd4; m_ready = 1'b1;
    c = 0;
    while (words_out != 16'hFFFF && c < 70000) begin
      @(negedge clk); #1;
      c++;
    end
    n_checks++;
    if (words_out !== 16'hFFFF || m_valid !== 1'b1) begin
      n_fail++; $display("FAIL wrap_preload: got words=%0d valid=%b want 65535 1", words_out, m_valid);
    end
    @(negedge clk); #1;
    n_checks++;
    if (words_out !== 16'd0) begin n_fail++; $display("FAIL wrap_zero: got %0d want 0", words_out); end
    fwr_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_stream();
    test_empty_fifo();
    test_backpressure();
    test_toggle_wrap();
    test_flush();
    test_async_reset();
    test_counter_wrap();
    n_checks++;
    if (inv_err !== 0) begin n_fail++; $display("FAIL buffer_invariant: got %0d violations want 0", inv_err); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
# fifo_rd_stream

Read-side drain engine for the team's synchronous FIFO (registered read data, `empty`/`full` flags, `fifo_cnt` occupancy). It issues FIFO read strobes, captures the one-cycle-late read data into a 3-entry output buffer, and presents the words downstream on a valid/ready stream at up to one word per clock. It also counts delivered words and supports a synchronous flush. It sits between any `sync_fifo` instance and its consumer.

## Interface
- `DATA_WIDTH`, 3, word width; must match the FIFO.
- `ADDR_WIDTH`, 3, FIFO address width; `fifo_cnt` is `ADDR_WIDTH+1` bits.
- `clk` in 1: the only clock; all state changes on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `fifo_rd_date` in `DATA_WIDTH`: FIFO registered read data, valid the cycle after an accepted read.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_cnt` in `ADDR_WIDTH+1`: FIFO occupancy, used only for the `drained` flag.
- `fifo_rd_en` out 1: read strobe to the FIFO.
- `m_valid` out 1: output word valid.
- `m_data` out `DATA_WIDTH`: output word, the head of the buffer.
- `m_ready` in 1: consumer accepts `m_data`.
- `flush` in 1: synchronous discard of all buffered and in-flight words.
- `words_out` out 16: count of delivered words.
- `drained` out 1: FIFO, buffer and pipeline are all empty.

## Operation
- **Internal state**
  - `pend` (1 bit): a read was accepted last cycle, so `fifo_rd_date` holds an uncaptured word this cycle.
  - `buf_cnt` (0..3).
  - `wr_ptr` / `rd_ptr` (2 bits each, sequence 0→1→2→0; value 3 is never used).
  - 3 × `DATA_WIDTH` storage entries.
- **Read strobe**
  - `fifo_rd_en = rst_n && !flush && (buf_cnt + pend < 3)`.
  - `fifo_rd_en` must not depend combinationally on `fifo_empty` or `m_ready`. The FIFO's `empty` depends on `rd_en`, so such a dependency creates a loop.
  - A read is accepted when `fifo_rd_en && !fifo_empty` at the clock edge. The next cycle `pend` is 1.
- **Capture**
  - Each edge with `pend==1 && !flush`: write `fifo_rd_date` to `entry[wr_ptr]`, then advance `wr_ptr`.
- **Pop**
  - A pop occurs when `m_valid && m_ready && !flush`. On each pop, advance `rd_ptr`.
- **Count update**
  - `buf_cnt` next value = `buf_cnt + capture − pop`.
  - Capture and pop in the same cycle leave `buf_cnt` unchanged.
  - The credit rule guarantees `buf_cnt` never exceeds 3. Exceeding it is a bug; the bench asserts against it.
- **Outputs**
  - `m_valid = (buf_cnt != 0)`.
  - `m_data = entry[rd_ptr]`. `m_data` is stable while `m_valid && !m_ready`.
  - `words_out` increments on each pop and wraps from 65535 to 0. It is cleared only by reset; `flush` does not clear it.
  - `drained = fifo_empty && fifo_cnt == 0 && !pend && buf_cnt == 0`.
- **Flush** (sampled at the edge)
  - Clears `buf_cnt`, `wr_ptr`, `rd_ptr` and `pend`.
  - An in-flight word (`pend==1`) is discarded, not captured.
  - `fifo_rd_en` is 0 during the flush cycle, so no new read occurs.
  - No pop is counted in the flush cycle, even if `m_ready==1`.
  - Entry contents are left as-is.
- **Reset (async)**
  - `pend=0`, `buf_cnt=0`, `wr_ptr=0`, `rd_ptr=0`, all entries 0, `words_out=0`.
  - While `rst_n` is low, outputs are: `fifo_rd_en=0`, `m_valid=0`, `m_data=0`, `words_out=0`.
  - Reset asserted mid-stream drops all words immediately. The FIFO is reset by the same `rst_n`.

## Timing
- **Latency:** a read accepted at edge E0 puts the word on `fifo_rd_date` in cycle 1. It is captured at E1 and `m_valid` rises in cycle 2. The word is delivered two cycles after the read strobe.
- **Throughput:** with `m_ready` held at 1 and the FIFO non-empty, `fifo_rd_en` stays 1 continuously and `m_valid` is 1 every cycle from cycle 2 onward.
- **Backpressure:** with `m_ready=0`, at most 3 words are buffered. `fifo_rd_en` deasserts once `buf_cnt + pend == 3`.
- **Resuming after backpressure:**
  - Raising `m_ready` pops one word per cycle.
  - `fifo_rd_en` re-asserts in the cycle after the first pop brings `buf_cnt + pend` below 3.
- **Pointer wrap:** pointers wrap from 2 to 0. Order is preserved across the wrap.
- **Empty FIFO:** `fifo_rd_en` may be 1 while `fifo_empty=1`. No read is accepted, `pend` stays 0, and the buffer is unaffected.

## Test plan
- **Reset, then FIFO holding 5,1,7 with `m_ready=1`:** `m_valid` rises 2 cycles after the first `fifo_rd_en`. Words 5,1,7 appear on consecutive cycles. `words_out=3`, then `drained=1`.
- **FIFO full (8 words), `m_ready=0` for 10 cycles:** exactly 3 reads are accepted, `buf_cnt=3`, `fifo_rd_en=0`, and `fifo_cnt` settles at 5. Then set `m_ready=1`: all 8 words come out in order with no gaps after the first, and `words_out=8`.
- **Toggle `m_ready` 1,0,1,0 over 20 words (values 0..7 repeating):** order is preserved through pointer wrap 2→0. No duplicates or drops.
- **Flush while `buf_cnt=2` and `pend=1`:** the next cycle `m_valid=0`, `buf_cnt=0` and `pend=0`. `words_out` is unchanged and the 3 words are lost. The following FIFO word is delivered next.
- **`rst_n` pulsed low asynchronously mid-stream (between edges):** `m_valid`, `fifo_rd_en` and `words_out` go to 0 immediately. Normal streaming resumes after release.
- **Counter wrap:** preload by streaming 65535 words, then deliver one more: `words_out` reads 0.
